// File: rtl/reduction_vector_writer_if.sv
// reduction_vector_writer_if: launch controls, input word stream and RAM write port of the vector writer.
// Carries zero_fill only when REDUCTION_WRITER_ZERO_FILL_EN is defined.
interface reduction_vector_writer_if #(
  parameter int DWIDTH = 20,
  parameter int AWIDTH = 11
);
  logic              start;
  logic [AWIDTH-1:0] start_addr;
  logic [AWIDTH-1:0] end_addr;
  logic [DWIDTH-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              ram_we;
  logic [AWIDTH-1:0] ram_addr;
  logic [DWIDTH-1:0] ram_wdata;
  logic              busy;
  logic              done;
  logic              err;
`ifdef REDUCTION_WRITER_ZERO_FILL_EN
  logic              zero_fill;
`endif
  modport slave (
`ifdef REDUCTION_WRITER_ZERO_FILL_EN
    input  zero_fill,
`endif
    input  start, start_addr, end_addr, in_data, in_valid,
    output in_ready, ram_we, ram_addr, ram_wdata, busy, done, err
  );
  modport master (
`ifdef REDUCTION_WRITER_ZERO_FILL_EN
    output zero_fill,
`endif
    output start, start_addr, end_addr, in_data, in_valid,
    input  in_ready, ram_we, ram_addr, ram_wdata, busy, done, err
  );
endinterface

// File: rtl/reduction_vector_writer.sv
// reduction_vector_writer: streams words into RAM addresses start_addr..end_addr, then pulses done.
// Optional REDUCTION_WRITER_ZERO_FILL_EN adds zero_fill, which writes zeros instead of consuming the stream.
module reduction_vector_writer #(
  parameter int DWIDTH = 20,
  parameter int AWIDTH = 11
) (
  input logic                     clk,
  input logic                     resetn,
  reduction_vector_writer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WRITE, FIN} state_t;
  state_t            r_state, w_state;
  logic              r_start_d, r_zero, w_zero;
  logic [AWIDTH-1:0] r_ptr, w_ptr, r_end, w_end, r_addr, w_addr;
  logic [DWIDTH-1:0] r_wdata, w_wdata;
  logic              r_ready, w_ready, r_we, w_we, r_busy, w_busy;
  logic              r_done, w_done, r_err, w_err;
  logic              w_launch, w_accept, w_zf;
`ifdef REDUCTION_WRITER_ZERO_FILL_EN
  assign w_zf = bus.zero_fill;
`else
  assign w_zf = 1'b0;
`endif
  assign w_launch = bus.start & ~r_start_d;
  // zero-fill mode advances every cycle without a stream handshake
  assign w_accept = r_zero | (bus.in_valid & r_ready);
  always_comb begin
    w_state = r_state;
    w_zero  = r_zero;
    w_ptr   = r_ptr;
    w_end   = r_end;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_ready = r_ready;
    w_we    = 1'b0;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_err   = r_err;
    if (r_state == IDLE && w_launch) begin
      if (bus.end_addr >= bus.start_addr) begin
        w_state = WRITE;
        w_ptr   = bus.start_addr;
        w_end   = bus.end_addr;
        w_busy  = 1'b1;
        w_ready = ~w_zf;
        w_zero  = w_zf;
        w_err   = 1'b0;
      end else begin
        w_state = FIN;
        w_err   = 1'b1;
      end
    end else if (r_state == WRITE && w_accept) begin
      w_we    = 1'b1;
      w_addr  = r_ptr;
      w_wdata = r_zero ? '0 : bus.in_data;
      // compare before increment so a range ending at the top address never wraps
      if (r_ptr == r_end) begin
        w_state = FIN;
        w_ready = 1'b0;
      end else begin
        w_ptr = r_ptr + AWIDTH'(1);
      end
    end else if (r_state == FIN) begin
      w_state = IDLE;
      w_busy  = 1'b0;
      w_done  = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_start_d <= 1'b0;
      r_zero    <= 1'b0;
      r_ptr     <= '0;
      r_end     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_ready   <= 1'b0;
      r_we      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_start_d <= bus.start;
      r_zero    <= w_zero;
      r_ptr     <= w_ptr;
      r_end     <= w_end;
      r_addr    <= w_addr;
      r_wdata   <= w_wdata;
      r_ready   <= w_ready;
      r_we      <= w_we;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_err     <= w_err;
    end
  end
  assign bus.in_ready  = r_ready;
  assign bus.ram_we    = r_we;
  assign bus.ram_addr  = r_addr;
  assign bus.ram_wdata = r_wdata;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
endmodule
